seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed 7-segment display scanner. Shares one 8-bit segment bus among
//  NDIG digits: drives one digit at a time with a dead (blank) interval between
//  digits to avoid ghosting. Digit values arrive via a request/ack load port and
//  are double-buffered, so a display refresh never shows a torn value.
//  Sits between the counter datapaths (mod-6/mod-10 chains) and the board display.
// PARAMETERS
//  NDIG       4     number of digits scanned (>=2)
//  DIV        1000  clock cycles per digit slot (blank + drive)
//  BLANK_CYC  16    cycles at the start of each slot with all digits off; 1 <= BLANK_CYC < DIV
// PORTS
//  CLK     in   1        clock; all state updates on posedge
//  RST     in   1        asynchronous, active-low reset
//  DIN     in   4*NDIG   digit codes 0x0-0xF; DIN[3:0] = digit 0 (least significant)
//  DP      in   NDIG     decimal point per digit, sampled live (not buffered)
//  LZB     in   1        1 = leading-zero blanking enabled
//  LD_REQ  in   1        load request; DIN must stay stable while LD_REQ=1 and LD_ACK=0
//  LD_ACK  out  1        one-cycle pulse: DIN captured into the shadow register
//  FRAME   out  1        one-cycle pulse at every frame boundary
//  SEG     out  8        segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, active-high
//  DIG     out  NDIG     digit enable, one-hot or all-zero, active-high
// BEHAVIOUR
//  - Reset (RST=0): immediate, no clock needed: SEG=0, DIG=0, LD_ACK=0, FRAME=0,
//    shadow=0, digit index=0, slot counter=0, state=BLANK. Applies mid-slot/mid-frame.
//  - All outputs registered. Per-slot output sequence starting at reset release:
//    BLANK_CYC cycles DIG=0/SEG=0, then DIV-BLANK_CYC cycles DIG=one-hot(idx), SEG=code.
//    idx goes 0,1,..,NDIG-1, then wraps to 0. Frame = NDIG*DIV cycles.
//  - FSM: BLANK (cnt < BLANK_CYC) -> DRIVE (cnt = BLANK_CYC..DIV-1) -> BLANK with idx+1.
//    cnt is 0..DIV-1, wraps to 0 on each slot end.
//  - Frame boundary = the edge on which idx wraps NDIG-1 -> 0. On that edge:
//    FRAME=1 for one cycle; if LD_REQ=1 then shadow<=DIN and LD_ACK=1 for one cycle.
//    The new value is shown from slot 0 of the new frame. LD_REQ is ignored at all
//    other times. No mid-frame update. LD_ACK is never asserted without LD_REQ.
//  - LD_REQ held high continuously: one capture + LD_ACK pulse per frame.
//  - Decode (bits 7..1 = a..g): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//    5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111
//    C=1001110 d=0111101 E=1001111 F=1000111. SEG[0]=DP[idx] during DRIVE.
//  - LZB=1: digit i>0 is blanked (a..g=0) if shadow digit i and every more-significant
//    digit are 0. Digit 0 is never blanked. DIG stays asserted and DP still shows.
//  - During BLANK, SEG=0 including dp; DIG=0. DIG never changes one-hot to one-hot
//    directly.
// TESTING  (NDIG=4, DIV=8, BLANK_CYC=2)
//  1 Reset: RST->0 mid-DRIVE -> SEG=0, DIG=0, LD_ACK=0 immediately. Release -> 2 blank
//    cycles, then DIG=4'b0001.
//  2 Scan: load 16'h0123 -> per slot: 2 cycles DIG=0, then 6 cycles DIG=0001/SEG=11110010,
//    0010/11011010, 0100/01100000, 1000/11111100. FRAME pulse every 32 cycles.
//  3 Load: LD_REQ=1, DIN=16'h5A3F mid-frame -> display unchanged until boundary; LD_ACK
//    for 1 cycle on boundary; next frame dig0=10001110, dig1=11110010, dig2=11101110,
//    dig3=10110110.
//  4 LZB: shadow 16'h0007, LZB=1, DP=4'b0100 -> dig3 SEG=0, dig2 SEG=00000001,
//    dig1 SEG=0, dig0 11100000. Shadow 0 -> dig0 shows 11111100. LZB=0 -> all shown.
//  5 Continuous LD_REQ=1 -> exactly one LD_ACK per 32 cycles, coincident with FRAME.
//  6 Digit switching: assert DIG is never one-hot-to-one-hot; >=2 zero cycles between
//    drives; SEG=0 whenever DIG=0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: one digit driven per slot, with a blank gap
// at the start of each slot and a double-buffered digit shadow that loads on frame boundaries.
module seg_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   din,
    input  logic [NDIG-1:0]     dp,
    input  logic                lzb,
    input  logic                ld_req,
    output logic                ld_ack,
    output logic                frame,
    output logic [7:0]          seg,
    output logic [NDIG-1:0]     dig
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [IW-1:0]       idx, idx_next;
    logic [4*NDIG-1:0]   shadow;
    logic                slot_end, frame_edge;
    logic [NDIG-1:0]     lz_blank;
    logic                zero_above;
    logic [3:0]          code;
    logic                code_blank, code_dp;
    logic [7:0]          seg_next;
    logic [NDIG-1:0]     dig_next;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        slot_end   = (cnt == CNT_MAX);
        frame_edge = slot_end && (idx == IDX_MAX);
        cnt_next   = slot_end ? '0 : cnt + 1'b1;
        idx_next   = idx;
        if (slot_end) begin
            idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
        state_next = state;
        case (state)
            BLANK:   if (cnt_next >= CNT_BLANK) state_next = DRIVE;
            DRIVE:   if (slot_end) state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        lz_blank   = '0;
        zero_above = lzb;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_above  = zero_above && (shadow[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
    end

    // Outputs are computed from the next state so the registered values line up with cnt.
    always_comb begin
        code       = '0;
        code_blank = 1'b0;
        code_dp    = 1'b0;
        dig_next   = '0;
        seg_next   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_next == IW'(i)) begin
                code       = shadow[4*i +: 4];
                code_blank = lz_blank[i];
                code_dp    = dp[i];
            end
        end
        if (state_next == DRIVE) begin
            for (int i = 0; i < NDIG; i++) begin
                dig_next[i] = (idx_next == IW'(i));
            end
            seg_next = {(code_blank ? 7'b0 : decode(code)), code_dp};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BLANK;
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            ld_ack <= 1'b0;
            frame  <= 1'b0;
            seg    <= '0;
            dig    <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            idx    <= idx_next;
            frame  <= frame_edge;
            ld_ack <= frame_edge && ld_req;
            if (frame_edge && ld_req) begin
                shadow <= din;
            end
            seg <= seg_next;
            dig <= dig_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NDIG=4, DIV=8, BLANK_CYC=2): table of loaded values
// with hand-decoded segments, plus reset, mid-frame load and continuous-request sequences.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [3:0]  dp;
    logic        lzb;
    logic        ld_req;
    logic        ld_ack;
    logic        frame;
    logic [7:0]  seg;
    logic [3:0]  dig;

    int errors;
    int checks;
    int k;
    int ack_count;
    logic ack_on_frame;

    typedef struct {
        logic [15:0]      din;
        logic             lzb;
        logic [3:0]       dp;
        logic [3:0][7:0]  segs;
    } vec_t;

    vec_t vecs[7];

    seg_scan_ctrl #(.NDIG(4), .DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dp(dp), .lzb(lzb),
        .ld_req(ld_req), .ld_ack(ld_ack), .frame(frame), .seg(seg), .dig(dig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d: got %b expected %b", nm, k, act, exp);
        end
    endtask

    // Expected scan position derives from k, the number of edges since reset release.
    task automatic check_cycle(input string nm, input logic [3:0][7:0] es);
        int c;
        int ix;
        logic [11:0] exp_v;
        logic exp_frame;
        c  = k % 8;
        ix = (k / 8) % 4;
        exp_v = (c < 2) ? 12'h000 : {4'b0001 << ix, es[ix]};
        exp_frame = (k % 32 == 0) && (k > 0);
        checks++;
        if ({dig, seg} !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s k=%0d: dig/seg got %b/%b expected %b/%b",
                     nm, k, dig, seg, exp_v[11:8], exp_v[7:0]);
        end
        check_bit({nm, "_frame"}, frame, exp_frame);
        check_bit({nm, "_ack"}, ld_ack, exp_frame && ack_on_frame);
        if (ld_ack) ack_count++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        k = 0;
        ack_count = 0;
        ack_on_frame = 1'b1;
        din = '0; dp = '0; lzb = 1'b0; ld_req = 1'b0;

        vecs[0] = '{16'h0123, 1'b0, 4'b0000, {8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010}};
        vecs[1] = '{16'h5A3F, 1'b0, 4'b0000, {8'b10110110, 8'b11101110, 8'b11110010, 8'b10001110}};
        vecs[2] = '{16'h0007, 1'b1, 4'b0100, {8'b00000000, 8'b00000001, 8'b00000000, 8'b11100000}};
        vecs[3] = '{16'h0000, 1'b1, 4'b0000, {8'b00000000, 8'b00000000, 8'b00000000, 8'b11111100}};
        vecs[4] = '{16'h0007, 1'b0, 4'b0100, {8'b11111100, 8'b11111101, 8'b11111100, 8'b11100000}};
        vecs[5] = '{16'h8B0C, 1'b1, 4'b1001, {8'b11111111, 8'b00111110, 8'b11111100, 8'b10011101}};
        vecs[6] = '{16'h0400, 1'b1, 4'b0000, {8'b00000000, 8'b01100110, 8'b11111100, 8'b11111100}};

        rst_n = 1'b0;
        #12;
        check_bit("rst_ack", ld_ack, 1'b0);
        check_bit("rst_frame", frame, 1'b0);
        check_cycle("rst_out", '0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;

        // Shadow is zero after reset, so every digit shows 0.
        check_cycle("init", {4{8'b11111100}});
        for (int i = 1; i < 32; i++) begin
            step();
            check_cycle("init", {4{8'b11111100}});
        end

        for (int v = 0; v < 7; v++) begin
            din = vecs[v].din; lzb = vecs[v].lzb; dp = vecs[v].dp; ld_req = 1'b1;
            step();
            check_cycle($sformatf("vec%0d", v), vecs[v].segs);
            ld_req = 1'b0;
            for (int i = 1; i < 32; i++) begin
                step();
                check_cycle($sformatf("vec%0d", v), vecs[v].segs);
            end
        end

        // Boundary without a request: FRAME pulses, no ack, display unchanged.
        ack_on_frame = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            check_cycle("noreq", vecs[6].segs);
        end

        // Request raised mid-frame must not disturb the current frame.
        for (int i = 0; i < 9; i++) begin
            step();
            check_cycle("midpre", vecs[6].segs);
        end
        din = 16'h5A3F; ld_req = 1'b1; ack_on_frame = 1'b1;
        for (int i = 0; i < 23; i++) begin
            step();
            check_cycle("midhold", vecs[6].segs);
        end
        ack_count = 0;
        for (int i = 0; i < 96; i++) begin
            step();
            check_cycle("contreq", vecs[1].segs);
        end
        checks++;
        if (ack_count != 3) begin
            errors++;
            $display("[TB] FAIL ack_count: got %0d expected 3", ack_count);
        end

        // Asynchronous reset in the middle of a drive interval.
        ld_req = 1'b0; dp = 4'b0000; lzb = 1'b0;
        while (k % 8 != 4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("arst_ack", ld_ack, 1'b0);
        checks++;
        if ({dig, seg} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL arst_out: got %b/%b expected 0000/00000000", dig, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        check_cycle("postrst", {4{8'b11111100}});
        for (int i = 1; i < 12; i++) begin
            step();
            check_cycle("postrst", {4{8'b11111100}});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
